// File: rtl/music_sequencer_if.sv
// music_sequencer_if: control buttons, score ROM port and note output of the music sequencer
interface music_sequencer_if #(parameter int ADDR_W = 6);
  logic play, pause, stop, loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0] rom_data;
  logic [4:0] music;
  logic note_valid, busy, paused, done;
  modport master(output play, pause, stop, loop_en, rom_data,
                 input rom_addr, music, note_valid, busy, paused, done);
  modport slave(input play, pause, stop, loop_en, rom_data,
                output rom_addr, music, note_valid, busy, paused, done);
endinterface

// File: rtl/music_sequencer.sv
// music_sequencer: walks a {dur, note} score ROM, holds each note for dur ticks, then a silent gap
module music_sequencer #(
  parameter int SYS_CLK = 50_000_000,
  parameter int TICK_HZ = 8,
  parameter int GAP_CYC = 2_500_000,
  parameter int SONG_LEN = 64,
  parameter int ADDR_W = 6
) (
  input logic clk,
  input logic rst,
  music_sequencer_if.slave bus
);
  localparam int TICK_CYC = SYS_CLK / TICK_HZ;
  localparam int TW = TICK_CYC > 1 ? $clog2(TICK_CYC) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYC - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SONG_LEN - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, PAUSED} state_t;
  state_t state, state_n, saved, saved_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [4:0] note, note_n;
  logic [3:0] rem, rem_n;
  logic [TW-1:0] tick, tick_n;
  logic [GW-1:0] gap, gap_n;
  logic done_q, done_n, pend, pend_n, fin, tick_w, gap_w;
  assign tick_w = tick == TICK_MAX;
  assign gap_w = gap == GAP_MAX;
  assign fin = (state == LOAD && bus.rom_data[8:5] == 4'd0) || (state == GAP && gap_w && addr == LAST);
  always_comb begin
    state_n = state;
    saved_n = saved;
    addr_n = addr;
    note_n = note;
    rem_n = rem;
    tick_n = tick;
    gap_n = gap;
    done_n = 1'b0;
    pend_n = pend;
    case (state)
      IDLE: state_n = bus.play ? FETCH : IDLE;
      FETCH: state_n = LOAD;
      LOAD: begin
        note_n = bus.rom_data[4:0];
        rem_n = bus.rom_data[8:5];
        tick_n = '0;
        state_n = PLAY;
      end
      PLAY: begin
        tick_n = tick_w ? '0 : tick + 1'b1;
        rem_n = tick_w ? rem - 1'b1 : rem;
        gap_n = '0;
        state_n = tick_w && rem == 4'd1 ? GAP : PLAY;
      end
      GAP: begin
        gap_n = gap + 1'b1;
        addr_n = gap_w ? addr + 1'b1 : addr;
        state_n = gap_w ? FETCH : GAP;
      end
      PAUSED: state_n = bus.play ? saved : PAUSED;
      default: state_n = IDLE;
    endcase
    if (fin) begin
      done_n = 1'b1;
      addr_n = '0;
      state_n = bus.loop_en ? FETCH : IDLE;
    end
    // a pause that would land outside PLAY/GAP is held until the next note is loaded
    if (bus.pause && state inside {FETCH, LOAD, PLAY, GAP}) begin
      if (state inside {PLAY, GAP} && state_n inside {PLAY, GAP}) begin
        saved_n = state_n;
        state_n = PAUSED;
      end else pend_n = 1'b1;
    end
    if (state == LOAD) begin
      if (pend_n && state_n == PLAY) begin
        saved_n = PLAY;
        state_n = PAUSED;
      end
      pend_n = 1'b0;
    end
    if (bus.stop) begin
      state_n = IDLE;
      addr_n = '0;
      done_n = 1'b0;
    end
    if (state_n == IDLE) pend_n = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      saved <= IDLE;
      addr <= '0;
      note <= '0;
      rem <= '0;
      tick <= '0;
      gap <= '0;
      done_q <= 1'b0;
      pend <= 1'b0;
    end else begin
      state <= state_n;
      saved <= saved_n;
      addr <= addr_n;
      note <= note_n;
      rem <= rem_n;
      tick <= tick_n;
      gap <= gap_n;
      done_q <= done_n;
      pend <= pend_n;
    end
  assign bus.rom_addr = addr;
  assign bus.music = state == PLAY ? note : 5'd0;
  assign bus.note_valid = state == PLAY && note != 5'd0;
  assign bus.busy = state != IDLE;
  assign bus.paused = state == PAUSED;
  assign bus.done = done_q;
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: expands the score into a per-cycle expected timeline and scoreboards the DUT against it
module tb_music_sequencer;
  localparam int TC = 10;
  localparam int GC = 2;
  localparam int SL = 4;
  localparam logic [2:0] K_I = 3'd0, K_F = 3'd1, K_L = 3'd2, K_P = 3'd3, K_G = 3'd4;
  typedef struct packed {logic [2:0] k; logic [4:0] n; logic d; logic [1:0] a;} item_t;
  typedef struct packed {logic [4:0] m; logic nv, b, p, d; logic [1:0] a;} out_t;
  logic clk = 1'b0;
  logic rst;
  logic [8:0] rom [SL];
  item_t cur, saved;
  item_t pl[$];
  out_t expq[$];
  bit pm, pend, loop;
  int n_cmp = 0, n_bad = 0;
  music_sequencer_if #(.ADDR_W(2)) bus();
  music_sequencer #(.SYS_CLK(100), .TICK_HZ(10), .GAP_CYC(GC), .SONG_LEN(SL), .ADDR_W(2))
    dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  function automatic item_t mk(input logic [2:0] k, input logic [4:0] n, input logic d, input logic [1:0] a);
    item_t t;
    t.k = k;
    t.n = n;
    t.d = d;
    t.a = a;
    return t;
  endfunction
  task automatic add_pass(input bit d0);
    for (int i = 0; i < SL; i++) begin
      pl.push_back(mk(K_F, 5'd0, d0 && i == 0, 2'(i)));
      pl.push_back(mk(K_L, 5'd0, 1'b0, 2'(i)));
      if (rom[i][8:5] == 4'd0) break;
      for (int j = 0; j < int'(rom[i][8:5]) * TC; j++) pl.push_back(mk(K_P, rom[i][4:0], 1'b0, 2'(i)));
      for (int j = 0; j < GC; j++) pl.push_back(mk(K_G, 5'd0, 1'b0, 2'(i)));
    end
    if (!loop) pl.push_back(mk(K_I, 5'd0, 1'b1, 2'd0));
  endtask
  task automatic adv(output item_t nx);
    if (pl.size() == 0 && loop && cur.k != K_I) add_pass(1'b1);
    nx = pl.size() != 0 ? pl.pop_front() : mk(K_I, 5'd0, 1'b0, 2'd0);
  endtask
  task automatic step(input bit p, input bit pa, input bit s);
    item_t nx;
    bit was_load;
    if (s) begin
      pl.delete();
      pm = 0;
      pend = 0;
      cur = mk(K_I, 5'd0, 1'b0, 2'd0);
    end else if (pm) begin
      if (p) begin
        pm = 0;
        cur = saved;
      end
    end else if (cur.k == K_I) begin
      if (p) begin
        pl.delete();
        add_pass(1'b0);
      end
      adv(nx);
      cur = nx;
    end else begin
      was_load = cur.k == K_L;
      if (pa) begin
        if ((cur.k == K_P || cur.k == K_G) && pl.size() != 0 && (pl[0].k == K_P || pl[0].k == K_G)) begin
          saved = pl.pop_front();
          pm = 1;
        end else pend = 1;
      end
      if (!pm) begin
        adv(nx);
        if (was_load) begin
          if (pend && nx.k == K_P) begin
            saved = nx;
            pm = 1;
          end
          pend = 0;
        end
        if (nx.k == K_I) pend = 0;
        cur = nx;
      end
    end
  endtask
  function automatic out_t expo();
    out_t o;
    o = '0;
    if (pm) begin
      o.b = 1'b1;
      o.p = 1'b1;
      o.a = saved.a;
    end else begin
      o.m = cur.k == K_P ? cur.n : 5'd0;
      o.nv = cur.k == K_P && cur.n != 5'd0;
      o.b = cur.k != K_I;
      o.d = cur.d;
      o.a = cur.a;
    end
    return o;
  endfunction
  task automatic chk(input string nm, input out_t e);
    out_t a;
    a = {bus.music, bus.note_valid, bus.busy, bus.paused, bus.done, bus.rom_addr};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got music=%0d nv=%b busy=%b paused=%b done=%b addr=%0d, want music=%0d nv=%b busy=%b paused=%b done=%b addr=%0d",
               nm, $time, a.m, a.nv, a.b, a.p, a.d, a.a, e.m, e.nv, e.b, e.p, e.d, e.a);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (expq.size() != 0) chk("cycle", expq.pop_front());
  end
  task automatic cyc(input bit p, input bit pa, input bit s);
    @(negedge clk);
    bus.play = p;
    bus.pause = pa;
    bus.stop = s;
    step(p, pa, s);
    expq.push_back(expo());
  endtask
  task automatic idle_n(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask
  task automatic set_loop(input bit l);
    loop = l;
    bus.loop_en = l;
  endtask
  task automatic def_rom();
    rom[0] = {4'd2, 5'd5};
    rom[1] = {4'd1, 5'd8};
    rom[2] = {4'd3, 5'd0};
    rom[3] = {4'd1, 5'd12};
  endtask
  initial begin
    rst = 1'b1;
    bus.play = 1'b0;
    bus.pause = 1'b0;
    bus.stop = 1'b0;
    set_loop(1'b0);
    def_rom();
    pm = 0;
    pend = 0;
    cur = mk(K_I, 5'd0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    chk("reset", '0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(100);
    set_loop(1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(120);
    cyc(1'b0, 1'b0, 1'b1);
    idle_n(2);
    set_loop(1'b0);
    rom[1] = {4'd0, 5'd7};
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(40);
    def_rom();
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(6);
    cyc(1'b0, 1'b1, 1'b0);
    idle_n(39);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(100);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(10);
    cyc(1'b0, 1'b1, 1'b1);
    idle_n(3);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(30);
    cyc(1'b0, 1'b0, 1'b1);
    idle_n(2);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", '0);
    pl.delete();
    pm = 0;
    pend = 0;
    cur = mk(K_I, 5'd0, 1'b0, 2'd0);
    bus.play = 1'b0;
    bus.pause = 1'b0;
    bus.stop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(30);
    for (int r = 0; r < 6; r++) begin
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < SL; i++) rom[i] = {4'($urandom_range(0, 4)), 5'($urandom_range(0, 31))};
      set_loop(1'($urandom_range(0, 1)));
      cyc(1'b1, 1'b0, 1'b0);
      repeat (400) cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
